// File: rtl/led_trail_pkg.sv
// Shared constants and helpers for the LED afterglow fader.
//
// Contents:
//   DefBw / DefPreW        - default brightness and prescaler widths
//   DecayExpBase/Step      - decay period P = 2^(DecayExpBase + DecayExpStep * decay_sel)
//   gamma_duty()           - squared-law duty mapping, used only when LED_TRAIL_GAMMA_EN
//                            is defined
package led_trail_pkg;

  localparam int unsigned DefBw        = 4;
  localparam int unsigned DefPreW      = 12;
  localparam int unsigned DecayExpBase = 6;
  localparam int unsigned DecayExpStep = 2;

  // (level * level) >> bw; supports brightness widths up to 8 bits.
  function automatic logic [15:0] gamma_duty(input logic [7:0] level, input int unsigned bw);
    logic [15:0] sq;
    sq = 16'(level) * 16'(level);
    return sq >> bw;
  endfunction

endpackage

// File: rtl/led_trail_channel.sv
// One LED channel of the afterglow fader.
//
// Holds the channel brightness level, derives its PWM duty and registers the LED bit.
// Build option: LED_TRAIL_GAMMA_EN selects the squared-law duty; otherwise duty = level.
//
// Ports:
//   clk_i      - clock
//   rst_ni     - asynchronous active-low reset
//   ena_i      - global enable; all state holds while low
//   set_i      - registered pattern bit; forces full brightness
//   tick_i     - decay tick shared from the top (already qualified by enable)
//   pwm_cnt_i  - shared free-running PWM counter
//   led_o      - registered PWM output
module led_trail_channel
  import led_trail_pkg::*;
#(
  parameter int unsigned BW = DefBw
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ena_i,
  input  logic          set_i,
  input  logic          tick_i,
  input  logic [BW-1:0] pwm_cnt_i,
  output logic          led_o
);

  localparam logic [BW-1:0] Max = '1;

  logic [BW-1:0] level_q, level_d;
  logic [BW-1:0] duty;
  logic          led_q, led_d;

  // Set beats decay, so a held pattern bit stays at full brightness across ticks.
  always_comb begin
    level_d = level_q;
    if (set_i) begin
      level_d = Max;
    end else if (tick_i && (level_q != '0)) begin
      level_d = level_q - BW'(1);
    end
  end

  always_comb begin
`ifdef LED_TRAIL_GAMMA_EN
    duty = BW'(gamma_duty(8'(level_q), BW));
`else
    duty = level_q;
`endif
    // Full level is forced solid; the compare alone would give only MAX of 2^BW cycles.
    led_d = (level_q == Max) || (pwm_cnt_i < duty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else if (ena_i) begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_trail_fader.sv
// LED afterglow fader: renders the pattern generator's LED bits as PWM brightness with
// a decaying trail. A set bit lights its channel at full brightness; once it drops, the
// level steps down by one every decay period P until dark.
//
// Build option: LED_TRAIL_GAMMA_EN (squared-law duty instead of linear). No port or
// latency difference between builds.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   ena        - global enable; all state holds while low
//   pat_in     - LED pattern, bit i lights channel i
//   decay_sel  - decay period P = 2^(6 + 2*decay_sel): 64, 256, 1024, 4096 clocks
//   led_out    - registered PWM output per channel
//   tick_out   - registered one-cycle decay tick
module led_trail_fader
  import led_trail_pkg::*;
#(
  parameter int unsigned NCH   = 8,
  parameter int unsigned BW    = DefBw,
  parameter int unsigned PRE_W = DefPreW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic [NCH-1:0] pat_in,
  input  logic [1:0]     decay_sel,
  output logic [NCH-1:0] led_out,
  output logic           tick_out
);

  logic [NCH-1:0]   pat_q;
  logic [BW-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRE_W-1:0] tick_mask;
  int unsigned      tick_exp;
  logic             tick;
  logic             tick_out_q;

  // The tick compares the live prescaler against the live mask, so a decay_sel change
  // applies at once; at worst the first period after the change is short.
  always_comb begin
    tick_exp  = DecayExpBase + DecayExpStep * {30'd0, decay_sel};
    tick_mask = ~({PRE_W{1'b1}} << tick_exp);
    tick      = ena && ((pre_cnt_q & tick_mask) == tick_mask);
    pwm_cnt_d = pwm_cnt_q + BW'(1);
    pre_cnt_d = pre_cnt_q + PRE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q      <= '0;
      pwm_cnt_q  <= '0;
      pre_cnt_q  <= '0;
      tick_out_q <= 1'b0;
    end else if (ena) begin
      pat_q      <= pat_in;
      pwm_cnt_q  <= pwm_cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      tick_out_q <= tick;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    led_trail_channel #(
      .BW(BW)
    ) u_channel (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .ena_i     (ena),
      .set_i     (pat_q[i]),
      .tick_i    (tick),
      .pwm_cnt_i (pwm_cnt_q),
      .led_o     (led_out[i])
    );
  end

  assign tick_out = tick_out_q;

endmodule

// File: doc/led_trail_fader.md
# led_trail_fader

Downstream output stage for the shift-register pattern generator: it takes the 8-bit LED pattern the generator drives each clock and renders it as PWM brightness with a decaying "afterglow" trail. A channel whose pattern bit is high lights at full brightness. Once the bit drops, brightness steps down at a selectable rate until the channel is dark. It sits between the pattern generator's outputs and the `uo_out` pads.

## Interface
Parameters:
- `NCH`, 8: number of channels.
- `BW`, 4: brightness and PWM counter width. Full brightness `MAX` = 2^BW-1.
- `PRE_W`, 12: prescaler width. Must be ≥ 12 so every decay period is reachable.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `ena`, in, 1: global enable. While low, all state holds.
- `pat_in`, in, NCH: pattern from the generator. Bit i high means channel i is lit.
- `decay_sel`, in, 2: decay period P = 2^(6+2·decay_sel) clocks, giving 64, 256, 1024 or 4096.
- `led_out`, out, NCH: registered PWM output per channel.
- `tick_out`, out, 1: registered one-cycle decay-tick pulse.

## Operation
- `pat_q`: a one-stage register capturing `pat_in` when `ena` is high.
- `pwm_cnt` (BW bits):
  - Free-running up-counter, advances when `ena` is high.
  - Wraps from MAX to 0.
- `pre_cnt` (PRE_W bits):
  - Free-running up-counter, advances when `ena` is high.
  - Internal `tick` = `ena` AND `pre_cnt` low (6+2·decay_sel) bits all ones.
  - `tick_out` is `tick` registered.
  - `decay_sel` changing mid-count takes effect immediately. The first period after a change may be short; no other glitch is permitted.
- Per-channel `level` (BW bits), updated only when `ena` is high. Priority order:
  1. `pat_q[i]` = 1: `level` ← MAX.
  2. Else, `tick` = 1 and `level` ≠ 0: `level` ← `level`-1.
  3. Else: hold.
- `level` saturates at 0. It never wraps below 0.
- Set and tick in the same cycle: set wins, and `level` stays MAX.
- Duty: `duty` = `level`, or the gamma-corrected value when configured (see Configuration).
- `led_out[i]` ← (`level` == MAX) OR (`pwm_cnt` < `duty`), registered when `ena` is high. Therefore:
  - `level` 0: always off.
  - `level` MAX: solid on.
  - Otherwise: high for `duty` of every 2^BW cycles.
- Reset (asynchronous, any time, including mid-decay): `pat_q`, `pwm_cnt`, `pre_cnt` and all `level` go to 0. `led_out` = 0 and `tick_out` = 0 while `rst_n` is low. Operation resumes on the first edge after release.

## Timing
- `pat_in[i]` rising, sampled at edge N: `pat_q[i]` = 1 after edge N; `level` = MAX after N+1; `led_out[i]` = 1 after N+2.
  - Pattern-to-LED latency is 2 cycles.
- `pat_q[i]` falling: the first decrement happens at the next `tick`.
- Full fade from MAX to 0 takes MAX ticks, i.e. between (MAX-1)·P+1 and MAX·P cycles.
- `tick_out`:
  - Pulse width is exactly 1 cycle.
  - Period is exactly P while `ena` is high and `decay_sel` is stable.
- `ena` low: no register changes and outputs hold their last value. `ena` high resumes on the following edge with no lost or extra counts.

## Configuration
- `LED_TRAIL_GAMMA_EN`:
  - Defined: `duty` = (`level`·`level`) >> BW. For BW=4 the levels map to 0,0,0,0,1,1,2,3,4,5,6,7,9,10,12,14. MAX is still forced solid on.
  - Undefined: `duty` = `level`, a linear fade.
  - No port or latency difference between the two builds.

## Structure
- Shared package `led_trail_pkg`:
  - Constants: default `BW`, default `PRE_W`, decay exponent base (6) and step (2).
  - Gamma function `gamma_duty(level)`, which is only referenced under the macro.
- Sub-module `led_trail_channel`:
  - Holds one channel's `level` register, duty computation and `led_out` bit.
  - Instantiated NCH times by generate.
  - Shares `pwm_cnt` and `tick` from the top-level instance.

## Test plan
- Reset: hold `rst_n` low with `pat_in`=8'hFF for 10 cycles → `led_out`=0 and `tick_out`=0 throughout. After release, `led_out`=8'hFF exactly 2 edges later.
- Linear fade, `decay_sel`=0, macro undefined: pulse `pat_in`=8'h01 for 1 cycle → `led_out[0]` solid until the first tick. Then 14 of 16 cycles high, dropping by one high-cycle per 64-cycle tick. Dark (0) after 15 ticks and stays 0. Other bits stay 0.
- Tick timing: `decay_sel`=3 → `tick_out` pulses 1 cycle wide, exactly 4096 cycles apart. Switching to `decay_sel`=1 gives a period of 256.
- Set/tick collision: hold `pat_in[3]`=1 across several ticks → `level`=15 and `led_out[3]` constantly 1. Release → first decrement at the next tick.
- Enable and mid-decay reset: drop `ena` for 100 cycles at `level`=9 → `led_out`, `tick_out`, `level` and counters frozen; resumes unchanged. Then assert `rst_n`=0 mid-decay → all outputs 0 immediately.
- Gamma: with `LED_TRAIL_GAMMA_EN` defined, at `level`=8 → `led_out` high 4 of 16 cycles. With it undefined → 8 of 16.
